rv32i_trace_buffer: RTL and testbench

- Parametrised hardware successor to the simulation-only PC/instruction monitor for the rv32i core.
- Captures retired {pc, instruction} pairs into a circular buffer while armed.
- Freezes a configurable number of samples after a trigger, then provides an oldest-first readout port.
- Sits beside the rv32i core, driven by the fetch/retire outputs; read by a debug host or the testbench.

---
 rtl/rv32i_trace_buffer.sv | 136 +++++++++++++
 tb/tb_rv32i_trace_buffer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/rv32i_trace_buffer.sv
// rv32i_trace_buffer: trigger-based circular trace of retired {pc, instruction} pairs with oldest-first readout; define TRACE_TIMESTAMP_EN to store a 32-bit cycle stamp per entry.
module rv32i_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            pc,
  input  logic [XLEN-1:0]            instruction,
  input  logic                       arm,
  input  logic                       trig,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [XLEN-1:0]            rd_pc,
  output logic [XLEN-1:0]            rd_instr,
`ifdef TRACE_TIMESTAMP_EN
  output logic [31:0]                rd_ts,
`endif
  output logic [$clog2(DEPTH):0]     count,
  output logic                       armed,
  output logic                       done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef TRACE_TIMESTAMP_EN
  localparam int EW = 2 * XLEN + 32;
`else
  localparam int EW = 2 * XLEN;
`endif
  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] remaining_q, remaining_d, post_cnt_q, post_cnt_d, count_q, count_d;
  logic rd_valid_q, rd_valid_d, we;
  logic [XLEN-1:0] rd_pc_q, rd_pc_d, rd_instr_q, rd_instr_d;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wdata, rd_word;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d, rd_ts_q, rd_ts_d;
  assign ts_d  = ts_q + 32'd1;
  assign wdata = {ts_q, pc, instruction};
  assign rd_ts = rd_ts_q;
  assign rd_ts_d = rd_valid_d ? rd_word[EW-1:2*XLEN] : rd_ts_q;
  // free-running cycle stamp and the registered stamp of the last readout
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ts_q    <= '0;
      rd_ts_q <= '0;
    end else begin
      ts_q    <= ts_d;
      rd_ts_q <= rd_ts_d;
    end
`else
  assign wdata = {pc, instruction};
`endif
  assign rd_word  = mem[rd_ptr_q];
  assign rd_valid = rd_valid_q;
  assign rd_pc    = rd_pc_q;
  assign rd_instr = rd_instr_q;
  assign count    = count_q;
  assign armed    = state_q == ARMED || state_q == POST;
  assign done     = state_q == DONE;
  // capture FSM, write pointer bookkeeping and readout sequencing
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    post_cnt_d  = post_cnt_q;
    count_d     = count_q;
    rd_valid_d  = 1'b0;
    we          = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d  = ARMED;
          wr_ptr_d = '0;
          count_d  = '0;
        end else if (state_q == DONE && rd_en && remaining_q != '0) begin
          rd_valid_d  = 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
        end
      end
      ARMED, POST: begin
        we = in_valid;
        if (in_valid) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q == CW'(DEPTH) ? count_q : count_q + 1'b1;
        end
        if (state_q == ARMED && trig) begin
          post_cnt_d = CW'(POST_TRIG);
          state_d    = POST_TRIG == 0 ? DONE : POST;
        end else if (state_q == POST && in_valid) begin
          post_cnt_d = post_cnt_q - 1'b1;
          state_d    = post_cnt_q == CW'(1) ? DONE : POST;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != DONE && state_d == DONE) begin
      rd_ptr_d    = count_d == CW'(DEPTH) ? wr_ptr_d : '0;
      remaining_d = count_d;
    end
  end
  assign rd_pc_d    = rd_valid_d ? rd_word[2*XLEN-1:XLEN] : rd_pc_q;
  assign rd_instr_d = rd_valid_d ? rd_word[XLEN-1:0] : rd_instr_q;
  // control and readout registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      post_cnt_q  <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_pc_q     <= '0;
      rd_instr_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      post_cnt_q  <= post_cnt_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      rd_pc_q     <= rd_pc_d;
      rd_instr_q  <= rd_instr_d;
    end
  // trace storage; contents are don't-care until written
  always_ff @(posedge clk)
    if (we) mem[wr_ptr_q] <= wdata;
endmodule

// File: tb/tb_rv32i_trace_buffer.sv
// tb_rv32i_trace_buffer: directed checks of capture, trigger, wrap, gaps, over-read and reset.
module tb_rv32i_trace_buffer;
  logic clk = 0, reset = 0, in_valid = 0, arm = 0, trig = 0, rd_en = 0;
  logic [31:0] pc = 0, instruction = 0, rd_pc, rd_instr;
  logic rd_valid, armed, done;
  logic [4:0] count;
  int n_chk = 0, n_bad = 0;
  rv32i_trace_buffer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .pc(pc), .instruction(instruction),
    .arm(arm), .trig(trig), .rd_en(rd_en), .rd_valid(rd_valid), .rd_pc(rd_pc),
    .rd_instr(rd_instr), .count(count), .armed(armed), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_arm;
    arm = 1;
    tick();
    arm = 0;
  endtask
  task automatic samp(input logic [31:0] p, input logic t);
    in_valid = 1; pc = p; instruction = 32'h13; trig = t;
    tick();
    in_valid = 0; trig = 0;
  endtask
  initial begin
    logic [31:0] gap_pc [7];
    logic gap_v [8];
    int nv;
    reset = 1;
    tick(); tick();
    reset = 0;
    chk("rst_armed", armed, 0);
    chk("rst_count", count, 0);
    // 1: asynchronous reset mid-cycle
    do_arm();
    chk("t1_armed_pre", armed, 1);
    samp(32'h40, 0);
    chk("t1_count_pre", count, 1);
    #2 reset = 1;
    #1;
    chk("t1_async_armed", armed, 0);
    chk("t1_async_count", count, 0);
    chk("t1_async_done", done, 0);
    chk("t1_async_rdv", rd_valid, 0);
    chk("t1_async_rdpc", rd_pc, 0);
    tick(); tick();
    reset = 0;
    trig = 1; tick(); trig = 0;
    chk("t1_trig_armed", armed, 0);
    chk("t1_trig_done", done, 0);
    // 2: basic capture, trigger at pc 0x14, post 4
    do_arm();
    for (int i = 0; i < 10; i++) begin
      samp(32'(4 * i), i == 5);
      chk($sformatf("t2_done_%0d", i), done, i == 9);
    end
    chk("t2_count", count, 10);
    rd_en = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("t2_rdv_%0d", k), rd_valid, 1);
      chk($sformatf("t2_rdpc_%0d", k), rd_pc, 32'(4 * k));
    end
    chk("t2_rdinstr", rd_instr, 32'h13);
    // 5: over-read then arm+rd_en
    tick();
    chk("t5_over_rdv", rd_valid, 0);
    chk("t5_over_rdpc", rd_pc, 32'h24);
    arm = 1; tick(); arm = 0; rd_en = 0;
    chk("t5_arm_armed", armed, 1);
    chk("t5_arm_rdv", rd_valid, 0);
    chk("t5_arm_count", count, 0);
    // 3: wrap with 40 samples, trigger at i=30
    for (int i = 0; i < 40; i++) begin
      samp(32'(4 * i), i == 30);
      if (i >= 33 && i <= 35) chk($sformatf("t3_done_%0d", i), done, i >= 34);
    end
    chk("t3_count", count, 16);
    rd_en = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("t3_rdv_%0d", k), rd_valid, 1);
      chk($sformatf("t3_rdpc_%0d", k), rd_pc, 32'h4C + 32'(4 * k));
    end
    tick();
    rd_en = 0;
    chk("t3_over_rdv", rd_valid, 0);
    // 4: trigger on an idle cycle, post samples separated by gaps
    do_arm();
    for (int i = 0; i < 3; i++) samp(32'h100 + 32'(4 * i), 0);
    trig = 1; tick(); trig = 0;
    chk("t4_trig_armed", armed, 1);
    gap_v = '{1, 0, 0, 1, 0, 1, 0, 1};
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (gap_v[i]) begin
        samp(32'h200 + 32'(4 * nv), 0);
        nv++;
      end else tick();
      chk($sformatf("t4_done_%0d", i), done, i == 7);
    end
    chk("t4_count", count, 7);
    gap_pc = '{32'h100, 32'h104, 32'h108, 32'h200, 32'h204, 32'h208, 32'h20C};
    rd_en = 1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("t4_rdpc_%0d", k), rd_pc, gap_pc[k]);
    end
    rd_en = 0;
    // 6: reset during POST with two post samples outstanding
    do_arm();
    samp(32'h300, 0);
    samp(32'h304, 1);
    samp(32'h308, 0);
    samp(32'h30C, 0);
    chk("t6_pre_armed", armed, 1);
    chk("t6_pre_count", count, 4);
    #2 reset = 1;
    #1;
    chk("t6_rst_count", count, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_armed", armed, 0);
    tick();
    reset = 0;
    trig = 1; tick(); trig = 0;
    samp(32'h400, 0);
    chk("t6_trig_armed", armed, 0);
    chk("t6_trig_done", done, 0);
    chk("t6_trig_count", count, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
